// File: rtl/sky130_fd_io__pwrdet_multi_pkg.sv
// Shared types and width helpers for the multi-supply power detector.
package sky130_fd_io__pwrdet_multi_pkg;

    typedef enum logic [1:0] {
        ST_DOWN = 2'b00,
        ST_QUAL = 2'b01,
        ST_UP   = 2'b10
    } pwrdet_state_e;

    // Debounce counter must hold DEB_CYCLES-1 plus one spare bit of headroom.
    function automatic int deb_width(input int cycles);
        return $clog2(cycles) + 1;
    endfunction

    // Startup counter must hold STARTUP_CYCLES plus one spare bit of headroom.
    function automatic int su_width(input int cycles);
        return $clog2(cycles + 1) + 1;
    endfunction

endpackage

// File: rtl/sky130_fd_io__pwrdet_supply_qual.sv
// One supply: two-flop synchroniser, DOWN/QUAL/UP debounce FSM, sticky brownout flag.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_DOWN | supply absent; waiting for the synchronised level to go high
//   ST_QUAL | level high; counting stable edges, any low sample restarts
//   ST_UP   | supply qualified; a single low sample drops straight to DOWN
module sky130_fd_io__pwrdet_supply_qual
    import sky130_fd_io__pwrdet_multi_pkg::*;
#(
    parameter int DEB_CYCLES = 16,
    parameter int DEB_W      = deb_width(DEB_CYCLES)
) (
    input  logic clk,
    input  logic rst_por_hv_n,
    input  logic sup_raw_i,
    input  logic flag_clr_i,
    output logic present_o,
    output logic brownout_o
);

    logic             s1_q;
    logic             s2_q;
    pwrdet_state_e    state_q, state_d;
    logic [DEB_W-1:0] cnt_q, cnt_d;
    logic             flag_q, flag_d;

    // Synchroniser for the asynchronous analog detector output; s1 feeds only s2.
    always_ff @(posedge clk or negedge rst_por_hv_n) begin
        if (!rst_por_hv_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= sup_raw_i;
            s2_q <= s1_q;
        end
    end

    // FSM, debounce counter and brownout flag registers.
    always_ff @(posedge clk or negedge rst_por_hv_n) begin
        if (!rst_por_hv_n) begin
            state_q <= ST_DOWN;
            cnt_q   <= '0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
        end
    end

    // Next-state logic; a brownout set in the same cycle as a clear wins.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        flag_d  = flag_q;
        if (flag_clr_i) begin
            flag_d = 1'b0;
        end
        case (state_q)
            ST_DOWN: begin
                if (s2_q) begin
                    state_d = ST_QUAL;
                    cnt_d   = DEB_W'(1);
                end
            end
            ST_QUAL: begin
                if (!s2_q) begin
                    state_d = ST_DOWN;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
                    state_d = ST_UP;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + DEB_W'(1);
                end
            end
            ST_UP: begin
                if (!s2_q) begin
                    state_d = ST_DOWN;
                    cnt_d   = '0;
                    flag_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_DOWN;
                cnt_d   = '0;
            end
        endcase
    end

    assign present_o  = (state_q == ST_UP);
    assign brownout_o = flag_q;

endmodule

// File: rtl/sky130_fd_io__pwrdet_multi_seq.sv
// Multi-supply power detector: per-supply qualification, channel gating and
// a global startup delay that produces all_good.
module sky130_fd_io__pwrdet_multi_seq
    import sky130_fd_io__pwrdet_multi_pkg::*;
#(
    parameter int NUM_SUPPLY     = 2,
    parameter int NUM_CH         = 3,
    parameter int DEB_CYCLES     = 16,
    parameter int STARTUP_CYCLES = 2000,
    parameter int DEB_W          = deb_width(DEB_CYCLES),
    parameter int SU_W           = su_width(STARTUP_CYCLES)
) (
    input  logic                         clk,
    input  logic                         rst_por_hv_n,
    input  logic [NUM_SUPPLY-1:0]        sup_raw,
    input  logic [NUM_SUPPLY*NUM_CH-1:0] in_hv,
    output logic [NUM_SUPPLY*NUM_CH-1:0] out_hv,
    output logic [NUM_SUPPLY-1:0]        present,
    output logic                         all_good,
    output logic [NUM_SUPPLY-1:0]        brownout_flag,
    input  logic                         flag_clr,
    output logic                         tie_lo_esd
);

    logic all_pres;
    logic good_w;

    for (genvar s = 0; s < NUM_SUPPLY; s++) begin : g_sup
        sky130_fd_io__pwrdet_supply_qual #(
            .DEB_CYCLES (DEB_CYCLES),
            .DEB_W      (DEB_W)
        ) u_qual (
            .clk          (clk),
            .rst_por_hv_n (rst_por_hv_n),
            .sup_raw_i    (sup_raw[s]),
            .flag_clr_i   (flag_clr),
            .present_o    (present[s]),
            .brownout_o   (brownout_flag[s])
        );
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            assign out_hv[s*NUM_CH+c] = in_hv[s*NUM_CH+c] & present[s];
        end
    end

    assign all_pres = &present;

    if (STARTUP_CYCLES == 0) begin : g_no_delay
        assign good_w = 1'b1;
    end else begin : g_delay
        logic [SU_W-1:0] su_cnt_q, su_cnt_d;
        logic            good_q, good_d;

        // Startup counter and good latch registers.
        always_ff @(posedge clk or negedge rst_por_hv_n) begin
            if (!rst_por_hv_n) begin
                su_cnt_q <= '0;
                good_q   <= 1'b0;
            end else begin
                su_cnt_q <= su_cnt_d;
                good_q   <= good_d;
            end
        end

        // Losing any supply restarts the full delay; good latches once the count completes.
        always_comb begin
            su_cnt_d = su_cnt_q;
            good_d   = good_q;
            if (!all_pres) begin
                su_cnt_d = '0;
                good_d   = 1'b0;
            end else if (!good_q) begin
                if (su_cnt_q == SU_W'(STARTUP_CYCLES - 1)) begin
                    good_d = 1'b1;
                end
                if (su_cnt_q != '1) begin
                    su_cnt_d = su_cnt_q + SU_W'(1);
                end
            end
        end

        assign good_w = good_q;
    end

    assign all_good   = good_w & all_pres;
    assign tie_lo_esd = 1'b0;

endmodule

// File: doc/sky130_fd_io__pwrdet_multi_seq.md
Name: sky130_fd_io__pwrdet_multi_seq

Overview:
Parametrised, clocked successor to the two-rail vddd/vddio power detector.
- Qualifies NUM_SUPPLY raw supply-present indications through a synchroniser and a debounce counter, with a fast-drop rule on loss.
- Gates NUM_CH level-shifted channels per supply and runs a global startup-delay counter that produces an all_good indication.
- Keeps sticky brownout flags per supply.
- Sits in the always-on HV domain beside the I/O ring; clocked by the always-on slow oscillator.

Parameters:
- NUM_SUPPLY, 2, number of independently detected supplies (1..8).
- NUM_CH, 3, gated channels per supply (1..8).
- DEB_CYCLES, 16, stable-high clock edges required to qualify a supply (>=2).
- STARTUP_CYCLES, 2000, clock edges from all-present to all_good (0 = no delay).
- DEB_W, $clog2(DEB_CYCLES)+1, debounce counter width (derived).
- SU_W, $clog2(STARTUP_CYCLES+1)+1, startup counter width (derived).

Ports:
- clk  input  1  always-on slow clock
- rst_por_hv_n  input  1  reset, asynchronous, active-low
- sup_raw  input  NUM_SUPPLY  raw analog-detector outputs, asynchronous to clk
- in_hv  input  NUM_SUPPLY*NUM_CH  channel inputs; bit s*NUM_CH+c belongs to supply s
- out_hv  output  NUM_SUPPLY*NUM_CH  gated channel outputs
- present  output  NUM_SUPPLY  qualified supply-present, registered
- all_good  output  1  every supply present and startup delay elapsed
- brownout_flag  output  NUM_SUPPLY  sticky "supply was lost after qualification"
- flag_clr  input  1  synchronous clear of all brownout_flag bits
- tie_lo_esd  output  1  constant 0

Behaviour:
- Reset (rst_por_hv_n=0, asynchronous):
  - all FSMs go to DOWN; all counters and synchroniser flops clear.
  - present, all_good, brownout_flag and out_hv are 0.
  - Reset asserted mid-operation takes effect immediately without waiting for clk.
  - Release is synchronous to the next clk edge.
- Synchroniser: two flops per supply (s1, s2). No logic on s1.
- Per-supply FSM, states DOWN, QUAL, UP, evaluated on s2:
  - DOWN: s2=1 -> QUAL with cnt=1. Otherwise stay.
  - QUAL: s2=0 -> DOWN with cnt=0; the glitch restarts qualification.
  - QUAL: s2=1 and cnt==DEB_CYCLES-1 -> UP. Otherwise cnt++.
  - UP: s2=0 -> DOWN (fast drop, no debounce) and brownout set. Otherwise stay.
  - present[s] = (state==UP), registered.
- Latency, counting edge 1 as the first edge that samples sup_raw=1:
  - Rise: present rises at edge 2+DEB_CYCLES, if sup_raw is held high throughout.
  - Drop: present falls at edge 3 after the first edge sampling 0.
  - A low pulse shorter than one clock period may be missed; this is accepted.
- Channel gating: out_hv[s*NUM_CH+c] = in_hv[s*NUM_CH+c] & present[s].
  - Purely combinational from the registered present.
  - X on in_hv propagates only while present[s]=1.
- Startup counter:
  - Clears whenever &present==0. Increments while &present==1 and good_reg==0.
  - good_reg sets on the edge where the counter reaches STARTUP_CYCLES-1 with &present still 1. It then holds.
  - all_good = good_reg & (&present), so it drops in the same cycle any present falls.
  - Re-qualification repeats the full STARTUP_CYCLES delay.
  - STARTUP_CYCLES=0: all_good = &present.
- Brownout flags:
  - Set on the UP->DOWN transition; held until flag_clr=1 at a clk edge.
  - Simultaneous set and flag_clr: set wins.
  - Flags are not set by DOWN/QUAL glitches.
- Counter widths: counters saturate and never wrap. Comparisons use unsigned widths DEB_W and SU_W.
- Supplies are independent. Simultaneous drops in several supplies set each flag on the same edge.

Decomposition:
- Package sky130_fd_io__pwrdet_multi_pkg holds:
  - the FSM state typedef (DOWN=2'b00, QUAL=2'b01, UP=2'b10);
  - the clog2-based width helper functions.
- Sub-module sky130_fd_io__pwrdet_supply_qual contains the synchroniser, FSM, debounce counter and brownout flag for one supply.
  - It is instantiated NUM_SUPPLY times via generate.
- Startup counter, channel gating and tie_lo_esd live in the top level.

Test Plan (NUM_SUPPLY=2, NUM_CH=3, DEB_CYCLES=4, STARTUP_CYCLES=8):
1. Reset, then sup_raw=2'b11 from edge 1 -> present=2'b11 at edge 6; all_good=1 at edge 14; out_hv tracks in_hv=6'b101101 from edge 6.
2. sup_raw[0] high with a 1-cycle low at edge 3 -> present[0] stays 0 and qualification restarts; present[0] rises 6 edges after the last 0 sample edge; brownout_flag[0]=0.
3. Both supplies UP and all_good=1, then sup_raw[1]=0 -> present[1]=0 at edge 3 after sampling; all_good=0 in the same cycle; out_hv[5:3]=0; brownout_flag=2'b10.
4. flag_clr=1 on the same edge as a new UP->DOWN of supply 0 -> brownout_flag[0]=1 (set wins); a subsequent lone flag_clr -> brownout_flag=0.
5. Re-qualify supply 1 after a drop -> all_good stays 0 for 8 edges after present[1] rises, then asserts.
6. rst_por_hv_n pulsed low mid-count, between clk edges -> all outputs 0 immediately and flags cleared; after release, qualification restarts from DOWN.
